// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort frame controller.
//   state_t   : controller states (PRIME, LOAD, SETTLE, DRAIN)
//   cnt_width : width of a counter that must hold values 0..r_sz
package sort_pkg;

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Width able to represent 0..r_sz inclusive; never less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned r_sz);
    return (r_sz < 1) ? 1 : $clog2(r_sz + 1);
  endfunction

endpackage

// File: rtl/sort_frame_ctrl.sv
// Frame controller for an external priority sorter.
// Each frame: the sorter is primed with R_SZ zeros, the frame's beats are
// pushed, then the beats are popped back out largest-first. A frame closes on
// s_last or when R_SZ beats have been taken (trunc pulses in that case).
//
// Build option: define SORT_FRAME_ASCENDING_EN to invert data on the way in
// and out, turning the output order into non-decreasing. Priming pushes 0 in
// both builds.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   s_valid/s_ready/s_data/s_last   input stream
//   m_valid/m_ready/m_data/m_last   sorted output stream
//   busy                   low only while waiting for the first beat of a frame
//   trunc                  pulse on the beat that forcibly closes a full frame
//   srt_hold/srt_is_input/srt_data_in/srt_data_out   sorter control and data
module sort_frame_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned HBIT = 15,
  parameter int unsigned R_SZ = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [HBIT:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [HBIT:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          trunc,
  output logic          srt_hold,
  output logic          srt_is_input,
  output logic [HBIT:0] srt_data_in,
  input  logic [HBIT:0] srt_data_out
);

  localparam int unsigned CW = cnt_width(R_SZ);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_LAST = CW'(R_SZ - 1);

  state_t        state;
  logic [CW-1:0] prime_cnt;
  logic [CW-1:0] cnt;

  logic          accept_c;
  logic          full_c;
  logic [HBIT:0] s_in_c;

  // Optional data inversion on both sides of the sorter.
`ifdef SORT_FRAME_ASCENDING_EN
  assign s_in_c = ~s_data;
  assign m_data = ~srt_data_out;
`else
  assign s_in_c = s_data;
  assign m_data = srt_data_out;
`endif

  assign accept_c = (state == LOAD) & s_valid & s_ready;
  assign full_c   = (cnt == CNT_LAST);
  assign trunc    = accept_c & ~s_last & full_c;

  // Sorter drive: hold unless this cycle is a prime push, a beat push or a pop.
  always_comb begin
    srt_hold     = 1'b1;
    srt_is_input = 1'b1;
    srt_data_in  = '0;
    if (rst_n) begin
      case (state)
        PRIME:  srt_hold = 1'b0;
        LOAD: begin
          srt_hold    = ~accept_c;
          srt_data_in = s_in_c;
        end
        SETTLE: srt_hold = 1'b1;
        DRAIN: begin
          srt_hold     = ~m_ready;
          srt_is_input = 1'b0;
        end
        default: srt_hold = 1'b1;
      endcase
    end
  end

  // Frame sequencing with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      prime_cnt <= '0;
      cnt       <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        PRIME: begin
          if (prime_cnt == CNT_LAST) begin
            state     <= LOAD;
            prime_cnt <= '0;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
          end else begin
            prime_cnt <= prime_cnt + CNT_ONE;
          end
        end
        LOAD: begin
          if (accept_c) begin
            cnt  <= cnt + CNT_ONE;
            busy <= 1'b1;
            if (s_last || full_c) begin
              state   <= SETTLE;
              s_ready <= 1'b0;
            end
          end
        end
        // One quiet cycle so data_out reflects the last push before draining.
        SETTLE: begin
          state   <= DRAIN;
          m_valid <= 1'b1;
          m_last  <= (cnt == CNT_ONE);
        end
        DRAIN: begin
          if (m_ready) begin
            cnt    <= cnt - CNT_ONE;
            m_last <= (cnt == CNT_TWO);
            if (cnt == CNT_ONE) begin
              state   <= PRIME;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Bench for sort_frame_ctrl with R_SZ=8, HBIT=7. Includes a behavioural
// sorter driven by the controller and a frame-level reference model.
module tb_sort_frame_ctrl;

  localparam int unsigned HBIT = 7;
  localparam int unsigned R_SZ = 8;

`ifdef SORT_FRAME_ASCENDING_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       trunc;
  logic       srt_hold;
  logic       srt_is_input;
  logic [7:0] srt_data_in;
  logic [7:0] srt_data_out;

  int checks = 0;
  int errors = 0;
  int trunc_seen = 0;

  logic [7:0] beat_d[$];
  bit         beat_l[$];
  logic [7:0] cur[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];

  always #5 clk = ~clk;

  sort_frame_ctrl #(.HBIT(HBIT), .R_SZ(R_SZ)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .trunc(trunc),
    .srt_hold(srt_hold), .srt_is_input(srt_is_input),
    .srt_data_in(srt_data_in), .srt_data_out(srt_data_out)
  );

  // Behavioural sorter: bounded multiset, push drops the minimum when over
  // capacity, pop removes the maximum, data_out is the current maximum.
  logic [7:0] srt_q[$];
  always @(posedge clk or negedge rst_n) begin : sorter_model
    int idx;
    logic [7:0] mx;
    if (!rst_n) begin
      srt_q.delete();
    end else if (!srt_hold) begin
      if (srt_is_input) begin
        srt_q.push_back(srt_data_in);
        if (srt_q.size() > R_SZ) begin
          idx = 0;
          foreach (srt_q[i]) if (srt_q[i] < srt_q[idx]) idx = i;
          srt_q.delete(idx);
        end
      end else if (srt_q.size() > 0) begin
        idx = 0;
        foreach (srt_q[i]) if (srt_q[i] > srt_q[idx]) idx = i;
        srt_q.delete(idx);
      end
    end
    mx = '0;
    foreach (srt_q[i]) if (srt_q[i] > mx) mx = srt_q[i];
    srt_data_out <= mx;
  end

  // Close the frame being collected: its beats come back fully sorted.
  task automatic close_frame();
    logic [7:0] a[$];
    logic [7:0] t;
    a = cur;
    for (int i = 0; i < a.size(); i++)
      for (int j = i + 1; j < a.size(); j++)
        if (ASC ? (a[j] < a[i]) : (a[j] > a[i])) begin
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
    foreach (a[i]) begin
      exp_d.push_back(a[i]);
      exp_l.push_back(i == a.size() - 1);
    end
    cur.delete();
  endtask

  // Stream beat_d/beat_l through the DUT. pv/pr are valid/ready percentages;
  // pr<0 applies the ready pattern 1,0,0,1 across drain cycles. Returns after
  // stop_after output handshakes when stop_after>0.
  task automatic run_stream(input int pv, input int pr, input int stop_after,
                            input int budget, input string name);
    int bi = 0;
    int cyc = 0;
    int outs = 0;
    int pc = 0;
    bit done = 0;
    bit acc, exp_trunc, prev_stall;
    logic [7:0] prev_d, exp_in;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    prev_stall = 0;
    prev_d = '0;
    while (!done) begin
      @(negedge clk);
      if (bi < beat_d.size() && $urandom_range(99) < pv) begin
        s_valid = 1'b1; s_data = beat_d[bi]; s_last = beat_l[bi];
      end else begin
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
      end
      m_ready = (pr < 0) ? pat[pc % 4] : ($urandom_range(99) < pr);
      #1;
      acc = s_valid && s_ready;
      exp_trunc = acc && !s_last && (cur.size() == R_SZ - 1);
      checks++;
      if (trunc !== exp_trunc) begin
        errors++;
        $display("FAIL %s trunc: got %b expected %b", name, trunc, exp_trunc);
      end
      if (trunc === 1'b1) trunc_seen++;
      if (acc) begin
        exp_in = ASC ? ~s_data : s_data;
        checks++;
        if (srt_hold !== 1'b0 || srt_is_input !== 1'b1 || srt_data_in !== exp_in) begin
          errors++;
          $display("FAIL %s push: hold=%b is_input=%b data_in=%0d expected 0/1/%0d",
                   name, srt_hold, srt_is_input, srt_data_in, exp_in);
        end
        cur.push_back(s_data);
        bi++;
        if (s_last || cur.size() == R_SZ) close_frame();
      end else if (s_ready === 1'b1) begin
        checks++;
        if (srt_hold !== 1'b1) begin
          errors++;
          $display("FAIL %s idle hold: got %b expected 1", name, srt_hold);
        end
      end
      if (m_valid === 1'b1) begin
        pc++;
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected output: data=%0d last=%b", name, m_data, m_last);
        end else if (m_data !== exp_d[0] || m_last !== exp_l[0]) begin
          errors++;
          $display("FAIL %s output: data=%0d last=%b expected data=%0d last=%b",
                   name, m_data, m_last, exp_d[0], exp_l[0]);
        end
        if (prev_stall) begin
          checks++;
          if (m_data !== prev_d) begin
            errors++;
            $display("FAIL %s stall stability: data=%0d expected %0d", name, m_data, prev_d);
          end
        end
        checks++;
        if (srt_hold !== !m_ready || srt_is_input !== 1'b0 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s drain ctrl: hold=%b is_input=%b s_ready=%b expected %b/0/0",
                   name, srt_hold, srt_is_input, s_ready, !m_ready);
        end
        prev_stall = !m_ready;
        prev_d = m_data;
        if (m_ready && exp_d.size() > 0) begin
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          outs++;
        end
      end else begin
        prev_stall = 0;
      end
      cyc++;
      if (bi == beat_d.size() && exp_d.size() == 0 && cur.size() == 0) done = 1;
      if (stop_after > 0 && outs >= stop_after) done = 1;
      if (!done && cyc > budget) begin
        errors++;
        $display("FAIL %s timeout: %0d beats sent of %0d, %0d outputs pending",
                 name, bi, beat_d.size(), exp_d.size());
        done = 1;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    beat_d.delete();
    beat_l.delete();
  endtask

  task automatic add_beat(input logic [7:0] d, input bit l);
    beat_d.push_back(d);
    beat_l.push_back(l);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'hA5;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || trunc !== 1'b0 ||
        busy !== 1'b1 || srt_hold !== 1'b1) begin
      errors++;
      $display("FAIL reset values: s_ready=%b m_valid=%b m_last=%b trunc=%b busy=%b hold=%b expected 0/0/0/0/1/1",
               s_ready, m_valid, m_last, trunc, busy, srt_hold);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      #1;
      checks++;
      if (k <= 8) begin
        if (srt_hold !== 1'b0 || srt_is_input !== 1'b1 || srt_data_in !== 8'd0 ||
            s_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL prime cycle %0d: hold=%b is_input=%b data_in=%0d s_ready=%b busy=%b expected 0/1/0/0/1",
                   k, srt_hold, srt_is_input, srt_data_in, s_ready, busy);
        end
        @(negedge clk);
      end else if (s_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL load entry: s_ready=%b busy=%b expected 1/0", s_ready, busy);
      end
    end
  endtask

  task automatic test_basic_frame();
    add_beat(8'd5, 0); add_beat(8'd200, 0); add_beat(8'd17, 0); add_beat(8'd200, 1);
    run_stream(100, 100, 0, 200, "basic");
  endtask

  task automatic test_trunc();
    trunc_seen = 0;
    for (int i = 1; i <= 9; i++) add_beat(8'(i), i == 9);
    run_stream(100, 100, 0, 300, "trunc");
    checks++;
    if (trunc_seen != 1) begin
      errors++;
      $display("FAIL trunc count: got %0d expected 1", trunc_seen);
    end
  endtask

  task automatic test_stall();
    add_beat(8'd40, 0); add_beat(8'd10, 0); add_beat(8'd90, 0); add_beat(8'd60, 1);
    run_stream(100, -1, 0, 300, "stall");
  endtask

  task automatic test_extremes();
    add_beat(8'd0, 0); add_beat(8'd255, 0); add_beat(8'd3, 1);
    run_stream(100, 100, 0, 200, "extremes");
  endtask

  task automatic test_reset_mid_drain();
    int n;
    add_beat(8'd5, 0); add_beat(8'd9, 0); add_beat(8'd2, 1);
    run_stream(100, 100, 1, 200, "mid_drain");
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || srt_hold !== 1'b1) begin
      errors++;
      $display("FAIL mid-drain reset: m_valid=%b m_last=%b hold=%b expected 0/0/1",
               m_valid, m_last, srt_hold);
    end
    cur.delete(); exp_d.delete(); exp_l.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (s_ready === 1'b1) break;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL re-prime length: got %0d cycles expected 8", n);
    end
    add_beat(8'd7, 1);
    run_stream(100, 100, 0, 200, "post_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nf;
      nf = int'($urandom_range(2, 5));
      for (int f = 0; f < nf; f++) begin
        int len;
        len = int'($urandom_range(1, 11));
        for (int i = 0; i < len; i++)
          add_beat((r % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom), i == len - 1);
      end
      run_stream(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 5000, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_trunc();
    test_stall();
    test_extremes();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
